// File: rtl/mmio_uart_fifo_if.sv
// CPU-side register bus of the FIFO UART: select, strobes, address, data and interrupt.
interface mmio_uart_fifo_if;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       irq;

    modport master (output cs, rd, wr, addr, data_in, input data_out, irq);
    modport slave  (input cs, rd, wr, addr, data_in, output data_out, irq);
endinterface

// File: rtl/mmio_uart_fifo.sv
// Memory-mapped UART with RX/TX FIFOs, runtime baud divisor, sticky error flags and a level IRQ.
// Both serial FSMs share one state encoding:
//   state | meaning
//   IDLE  | line idle; RX waits for a low level, TX waits for FIFO data
//   START | start bit in progress
//   DATA  | data bits, LSB first
//   STOP  | stop bit
module mmio_uart_fifo #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    mmio_uart_fifo_if.slave bus,
    input  logic            rx,
    output logic            tx
);
    localparam logic [15:0]      DIV_RST  = 16'(CLK_FREQ / (16 * BAUD));
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [FIFO_AW:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    typedef logic [DATA_BITS-1:0] data_t;

    logic             rd_q, wr_q, rd_edge, wr_edge;
    logic [7:0]       data_out_q, rd_val;
    logic             irq_q, rx_ien, tx_ien;
    logic             frame_err, rx_ovr, tx_drop;
    logic [15:0]      div, div_new, tick_cnt;
    logic             baud_wr, tick;
    data_t            rx_mem [2**FIFO_AW];
    data_t            tx_mem [2**FIFO_AW];
    logic [FIFO_AW:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic             rx_empty, rx_full, tx_empty, tx_full;
    logic             rx_push_req, rx_push, rx_pop, tx_push_req, tx_push, tx_pop;
    logic             rx_ovr_set, tx_drop_set, frame_err_set;
    logic             rx_s1, rx_s2;
    state_t           rx_state, rx_state_n, tx_state, tx_state_n;
    logic [3:0]       rx_tcnt, rx_tcnt_n, tx_tcnt, tx_tcnt_n;
    logic [2:0]       rx_bcnt, rx_bcnt_n, tx_bcnt, tx_bcnt_n;
    data_t            rx_shift, rx_shift_n, tx_shift, tx_shift_n;
    logic             tx_line_n;

    function automatic logic [15:0] reload(input logic [15:0] d);
        return (d == 16'd0) ? 16'd0 : d - 16'd1;
    endfunction

    assign rd_edge      = bus.cs & bus.rd & ~rd_q;
    assign wr_edge      = bus.cs & bus.wr & ~wr_q;
    assign bus.data_out = data_out_q;
    assign bus.irq      = irq_q;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) && (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) && (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);

    // A push into a full FIFO still lands when the same clock frees a slot.
    assign rx_pop      = rd_edge & (bus.addr == 3'd0) & ~rx_empty;
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign rx_ovr_set  = rx_push_req & rx_full & ~rx_pop;
    assign tx_push_req = wr_edge & (bus.addr == 3'd0);
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign tx_drop_set = tx_push_req & tx_full & ~tx_pop;

    assign baud_wr = wr_edge & ((bus.addr == 3'd3) | (bus.addr == 3'd4));
    assign tick    = (tick_cnt == 16'd0);

    always_comb begin
        div_new = div;
        if (bus.addr == 3'd3) div_new[7:0]  = bus.data_in;
        else                  div_new[15:8] = bus.data_in;
    end

    always_comb begin
        rd_val = 8'h00;
        case (bus.addr)
            3'd0: rd_val = rx_empty ? 8'h00 : 8'(rx_mem[rx_rp[FIFO_AW-1:0]]);
            3'd1: rd_val = {1'b0, frame_err, rx_ovr, tx_drop, tx_full, tx_empty, rx_full, rx_empty};
            3'd2: rd_val = {6'd0, tx_ien, rx_ien};
            3'd3: rd_val = div[7:0];
            3'd4: rd_val = div[15:8];
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= 1'b0;  wr_q <= 1'b0;
            data_out_q <= 8'h00;
            irq_q <= 1'b0;
            rx_ien <= 1'b0;  tx_ien <= 1'b0;
            frame_err <= 1'b0;  rx_ovr <= 1'b0;  tx_drop <= 1'b0;
            div <= DIV_RST;
            tick_cnt <= reload(DIV_RST);
            rx_wp <= '0;  rx_rp <= '0;  tx_wp <= '0;  tx_rp <= '0;
            rx_s1 <= 1'b1;  rx_s2 <= 1'b1;
            tx <= 1'b1;
        end else begin
            rd_q <= bus.cs & bus.rd;
            wr_q <= bus.cs & bus.wr;
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            tx <= tx_line_n;
            if (rd_edge) data_out_q <= rd_val;
            if (baud_wr) begin
                div <= div_new;
                tick_cnt <= reload(div_new);
            end else if (tick) begin
                tick_cnt <= reload(div);
            end else begin
                tick_cnt <= tick_cnt - 16'd1;
            end
            if (wr_edge && bus.addr == 3'd2) begin
                rx_ien <= bus.data_in[0];
                tx_ien <= bus.data_in[1];
                if (bus.data_in[4]) begin
                    frame_err <= 1'b0;  rx_ovr <= 1'b0;  tx_drop <= 1'b0;
                end
            end
            // New error events win over a clear in the same clock.
            if (frame_err_set) frame_err <= 1'b1;
            if (rx_ovr_set)    rx_ovr    <= 1'b1;
            if (tx_drop_set)   tx_drop   <= 1'b1;
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            irq_q <= (rx_ien & ~rx_empty) | (tx_ien & tx_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_shift;
        if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= bus.data_in[DATA_BITS-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= IDLE;  rx_tcnt <= '0;  rx_bcnt <= '0;  rx_shift <= '0;
            tx_state <= IDLE;  tx_tcnt <= '0;  tx_bcnt <= '0;  tx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;  rx_tcnt <= rx_tcnt_n;  rx_bcnt <= rx_bcnt_n;  rx_shift <= rx_shift_n;
            tx_state <= tx_state_n;  tx_tcnt <= tx_tcnt_n;  tx_bcnt <= tx_bcnt_n;  tx_shift <= tx_shift_n;
        end
    end

    // RX: mid-bit sampling, 8 ticks into the start bit and every 16 ticks after.
    always_comb begin
        rx_state_n = rx_state;  rx_tcnt_n = rx_tcnt;  rx_bcnt_n = rx_bcnt;  rx_shift_n = rx_shift;
        rx_push_req = 1'b0;
        frame_err_set = 1'b0;
        case (rx_state)
            IDLE: if (!rx_s2) begin
                rx_state_n = START;
                rx_tcnt_n  = 4'd0;
            end
            START: if (tick) begin
                rx_tcnt_n = rx_tcnt + 4'd1;
                if (rx_tcnt == 4'd7) begin
                    rx_tcnt_n  = 4'd0;
                    rx_bcnt_n  = 3'd0;
                    rx_state_n = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: if (tick) begin
                rx_tcnt_n = rx_tcnt + 4'd1;
                if (rx_tcnt == 4'd15) begin
                    rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
                    rx_bcnt_n  = rx_bcnt + 3'd1;
                    if (rx_bcnt == LAST_BIT) rx_state_n = STOP;
                end
            end
            STOP: if (tick) begin
                rx_tcnt_n = rx_tcnt + 4'd1;
                if (rx_tcnt == 4'd15) begin
                    rx_state_n    = IDLE;
                    rx_push_req   = rx_s2;
                    frame_err_set = ~rx_s2;
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

    always_comb begin
        tx_state_n = tx_state;  tx_tcnt_n = tx_tcnt;  tx_bcnt_n = tx_bcnt;  tx_shift_n = tx_shift;
        tx_pop = 1'b0;
        case (tx_state)
            IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_n = tx_mem[tx_rp[FIFO_AW-1:0]];
                tx_tcnt_n  = 4'd0;
                tx_state_n = START;
            end
            START: if (tick) begin
                tx_tcnt_n = tx_tcnt + 4'd1;
                if (tx_tcnt == 4'd15) begin
                    tx_bcnt_n  = 3'd0;
                    tx_state_n = DATA;
                end
            end
            DATA: if (tick) begin
                tx_tcnt_n = tx_tcnt + 4'd1;
                if (tx_tcnt == 4'd15) begin
                    tx_shift_n = tx_shift >> 1;
                    tx_bcnt_n  = tx_bcnt + 3'd1;
                    if (tx_bcnt == LAST_BIT) tx_state_n = STOP;
                end
            end
            STOP: if (tick) begin
                tx_tcnt_n = tx_tcnt + 4'd1;
                if (tx_tcnt == 4'd15) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_mem[tx_rp[FIFO_AW-1:0]];
                        tx_state_n = START;
                    end else begin
                        tx_state_n = IDLE;
                    end
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    always_comb begin
        case (tx_state_n)
            START:   tx_line_n = 1'b0;
            DATA:    tx_line_n = tx_shift_n[0];
            default: tx_line_n = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_fifo.sv
// Randomized scoreboard bench for mmio_uart_fifo: queue-based reference model, bus-read and serial-line monitors.
module tb_mmio_uart_fifo;
    localparam int BIT_CLKS = 64;

    logic clk = 1'b0;
    logic rst;
    logic rx, rx_drv, loop, tx;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_rd_q [$];
    string      nm_q [$];
    logic [7:0] exp_tx_q [$];
    logic [7:0] rx_model [$];
    bit         tx_mon_en = 1'b0;
    bit         m_frame_err, m_rx_ovr, m_tx_drop;
    int         m_tx_cnt;

    mmio_uart_fifo_if bus ();

    mmio_uart_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .rx  (rx),
        .tx  (tx)
    );

    assign rx = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [7:0] m_status();
        return {1'b0, m_frame_err, m_rx_ovr, m_tx_drop, m_tx_cnt == 16, m_tx_cnt == 0,
                rx_model.size() == 16, rx_model.size() == 0};
    endfunction

    function automatic void model_reset();
        rx_model.delete();
        m_frame_err = 1'b0;
        m_rx_ovr    = 1'b0;
        m_tx_drop   = 1'b0;
        m_tx_cnt    = 0;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1;  bus.wr = 1'b1;  bus.addr = a;  bus.data_in = d;
        @(negedge clk);
        bus.cs = 1'b0;  bus.wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [7:0] e, input string nm, input int hold = 1);
        @(negedge clk);
        exp_rd_q.push_back(e);
        nm_q.push_back(nm);
        bus.cs = 1'b1;  bus.rd = 1'b1;  bus.addr = a;
        repeat (hold) @(negedge clk);
        bus.cs = 1'b0;  bus.rd = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        rx_drv = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            wait_clks(BIT_CLKS);
        end
        if (stop_ok) begin
            rx_drv = 1'b1;
            wait_clks(BIT_CLKS);
        end else begin
            rx_drv = 1'b0;
            wait_clks(48);
            rx_drv = 1'b1;
            wait_clks(16);
        end
        wait_clks(8);
    endtask

    task automatic loop_bytes(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            bus_write(3'd0, b);
            exp_tx_q.push_back(b);
            rx_model.push_back(b);
        end
        wait_clks(n * 660 + 100);
    endtask

    // Read monitor: one comparison per rising cs&rd, one clock later.
    initial begin : rd_mon
        bit prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.cs && bus.rd && !prev) begin
                prev = 1'b1;
                @(negedge clk);
                if (exp_rd_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected read: got %0h want none", bus.data_out);
                end else begin
                    check(nm_q.pop_front(), 16'(bus.data_out), 16'(exp_rd_q.pop_front()));
                end
            end else begin
                prev = bus.cs && bus.rd;
            end
        end
    end

    // Serial monitor: decodes frames on tx at divisor 4 and checks them against written bytes.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_mon_en && tx === 1'b0) begin
                wait_clks(BIT_CLKS / 2);
                check("tx start bit", 16'(tx), 16'd0);
                for (int i = 0; i < 8; i++) begin
                    wait_clks(BIT_CLKS);
                    b[i] = tx;
                end
                wait_clks(BIT_CLKS);
                check("tx stop bit", 16'(tx), 16'd1);
                if (exp_tx_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected tx frame: got %0h want none", b);
                end else begin
                    check("tx frame", 16'(b), 16'(exp_tx_q.pop_front()));
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] b;
        rst = 1'b1;
        bus.cs = 1'b0;  bus.rd = 1'b0;  bus.wr = 1'b0;  bus.addr = 3'd0;  bus.data_in = 8'h00;
        rx_drv = 1'b1;
        loop = 1'b0;
        model_reset();
        wait_clks(3);
        check("reset tx", 16'(tx), 16'd1);
        check("reset irq", 16'(bus.irq), 16'd0);
        check("reset data_out", 16'(bus.data_out), 16'd0);
        rst = 1'b0;
        wait_clks(2);

        bus_read(3'd1, m_status(), "status after reset");
        bus_read(3'd3, 8'd27, "baud_lo reset");
        bus_read(3'd4, 8'd0, "baud_hi reset");
        bus_read(3'd2, 8'd0, "ctrl reset");
        bus_read(3'd0, 8'd0, "data empty");
        bus_write(3'd5, 8'hFF);
        bus_read(3'd5, 8'd0, "reg5 reads 0");
        bus_read(3'd7, 8'd0, "reg7 reads 0");

        bus_write(3'd3, 8'd4);
        bus_write(3'd4, 8'd0);
        bus_read(3'd3, 8'd4, "baud_lo readback");

        loop = 1'b1;
        tx_mon_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            loop_bytes($urandom_range(1, 4));
            bus_read(3'd1, m_status(), "status loopback");
            while (rx_model.size() != 0) bus_read(3'd0, rx_model.pop_front(), "data loopback");
            bus_read(3'd1, m_status(), "status drained");
        end

        loop_bytes(2);
        bus_read(3'd0, rx_model.pop_front(), "held rd byte1", 20);
        bus_read(3'd0, rx_model.pop_front(), "read byte2");
        bus_read(3'd1, m_status(), "status after held rd");

        bus_write(3'd2, 8'h02);
        wait_clks(2);
        check("irq tx_empty", 16'(bus.irq), 16'd1);
        bus_read(3'd2, 8'h02, "ctrl readback");
        bus_write(3'd2, 8'h00);
        wait_clks(2);
        check("irq disabled", 16'(bus.irq), 16'd0);
        loop_bytes(1);
        bus_write(3'd2, 8'h01);
        wait_clks(2);
        check("irq rx data", 16'(bus.irq), 16'd1);
        bus_read(3'd0, rx_model.pop_front(), "data irq byte");
        wait_clks(2);
        check("irq rx drained", 16'(bus.irq), 16'd0);
        bus_write(3'd2, 8'h00);

        tx_mon_en = 1'b0;
        check("tx frames all seen", 16'(exp_tx_q.size()), 16'd0);
        loop = 1'b0;

        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            if (rx_model.size() < 16) rx_model.push_back(b);
            else m_rx_ovr = 1'b1;
        end
        wait_clks(20);
        bus_read(3'd1, m_status(), "status rx overflow");
        while (rx_model.size() != 0) bus_read(3'd0, rx_model.pop_front(), "data overflow order");
        bus_read(3'd0, 8'd0, "data empty after drain");
        bus_write(3'd2, 8'h10);
        m_rx_ovr = 1'b0;
        bus_read(3'd1, m_status(), "status ovr cleared");

        send_frame(8'($urandom), 1'b0);
        m_frame_err = 1'b1;
        wait_clks(20);
        bus_read(3'd1, m_status(), "status frame_err");
        bus_write(3'd2, 8'h10);
        m_frame_err = 1'b0;
        bus_read(3'd1, m_status(), "status frame_err cleared");
        b = 8'($urandom);
        send_frame(b, 1'b1);
        rx_model.push_back(b);
        bus_read(3'd1, m_status(), "status after recovery");
        bus_read(3'd0, rx_model.pop_front(), "data after recovery");

        bus_write(3'd3, 8'hFF);
        bus_write(3'd4, 8'hFF);
        bus_write(3'd0, 8'($urandom));
        wait_clks(3);
        for (int i = 0; i < 15; i++) begin
            bus_write(3'd0, 8'($urandom));
            m_tx_cnt++;
        end
        bus_read(3'd1, m_status(), "status tx 15 queued");
        bus_write(3'd0, 8'($urandom));
        m_tx_cnt++;
        bus_read(3'd1, m_status(), "status tx full");
        bus_write(3'd0, 8'($urandom));
        m_tx_drop = 1'b1;
        bus_read(3'd1, m_status(), "status tx drop");
        wait_clks(2);
        rst = 1'b1;
        #1;
        check("tx high on reset in start bit", 16'(tx), 16'd1);
        wait_clks(2);
        rst = 1'b0;
        model_reset();
        bus_read(3'd1, m_status(), "status after stall reset");

        bus_write(3'd3, 8'd4);
        bus_write(3'd4, 8'd0);
        bus_write(3'd2, 8'h02);
        bus_write(3'd0, 8'h00);
        wait_clks(200);
        check("tx low mid data bit", 16'(tx), 16'd0);
        check("irq before reset", 16'(bus.irq), 16'd1);
        rst = 1'b1;
        #1;
        check("tx high on reset mid data", 16'(tx), 16'd1);
        check("irq cleared by reset", 16'(bus.irq), 16'd0);
        check("data_out cleared by reset", 16'(bus.data_out), 16'd0);
        wait_clks(2);
        rst = 1'b0;
        model_reset();
        bus_read(3'd1, m_status(), "status after mid-tx reset");
        bus_read(3'd3, 8'd27, "baud_lo after reset");
        bus_read(3'd4, 8'd0, "baud_hi after reset");
        bus_read(3'd2, 8'd0, "ctrl after reset");

        for (int i = 0; i < 200 && exp_rd_q.size() != 0; i++) @(negedge clk);
        wait_clks(2);
        check("pending reads", 16'(exp_rd_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
